fetch_sequencer: RTL and testbench

Controller that sequences the two-word instruction window of `core`. It fetches 32-bit words from instruction memory into `ir0`/`ir1` and issues one variable-length instruction per handshake. It advances `pc` by the decoded length and shifts the window when `pc` crosses into the high word. It sits between the instruction-memory port and `core`, driving all of `core`'s load and enable inputs.

---
 rtl/quark_pkg.sv | 15 +
 rtl/tail_length.sv | 15 +
 rtl/fetch_sequencer.sv | 154 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/quark_pkg.sv
// Shared fetch-path types and window geometry for the quark core.
package quark_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL0,
        FILL1,
        RUN,
        HALT
    } fetch_state_e;

    localparam int WIN_NIBS  = 16;
    localparam int HALF_NIBS = 8;

endpackage

// File: rtl/tail_length.sv
// Instruction size decode from the head nibble; 0 marks an illegal encoding.
module tail_length (
    input  logic [3:0] nib_i,
    output logic [2:0] len_o
);

    always_comb begin
        len_o = 3'd0;
        if (nib_i[1:0] == 2'b00 || (nib_i[3] && !nib_i[1])) len_o = 3'd1;
        else if (nib_i == 4'b0001)                           len_o = 3'd2;
        else if (nib_i == 4'b0010)                           len_o = 3'd3;
        else if (nib_i == 4'b0011)                           len_o = 3'd4;
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Sequences the two-word instruction window of core: fills ir0/ir1, issues one
// variable-length instruction per handshake and shifts the window past ir0.
module fetch_sequencer
    import quark_pkg::*;
#(
    parameter int AW = 30
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_waddr,
    input  logic [2:0]    redirect_nib,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [31:0]   mem_rdata,
    input  logic [31:0]   ir0,
    input  logic [31:0]   ir1,
    input  logic [3:0]    pc,
    output logic [31:0]   ir0_next,
    output logic [31:0]   ir1_next,
    output logic          ir0_en,
    output logic          ir1_en,
    output logic [3:0]    pc_next,
    output logic          pc_en,
    output logic          issue_valid,
    input  logic          issue_ready,
    output logic [3:0]    issue_pc,
    output logic [2:0]    issue_len,
    output logic          issue_illegal
);

    localparam logic [4:0] HALF = 5'(HALF_NIBS);

    fetch_state_e  state_q, state_d;
    logic [AW-1:0] fa_q, fa_d;

    logic [4*WIN_NIBS-1:0] win;
    logic [3:0]            head;
    logic [2:0]            size;
    logic [4:0]            npc;
    logic                  legal;
    logic                  redir;
    logic                  hs;

    assign win   = {ir1, ir0};
    assign head  = win[{pc, 2'b00} +: 4];
    assign legal = (size != 3'd0);
    assign npc   = {1'b0, pc} + {2'b00, size};
    // A held reset must not leak redirect-driven loads to core.
    assign redir = redirect & reset_n;

    tail_length u_tail_length (
        .nib_i (head),
        .len_o (size)
    );

    always_comb begin
        state_d  = state_q;
        fa_d     = fa_q;
        mem_req  = 1'b0;
        mem_addr = '0;
        ir0_en   = 1'b0;
        ir0_next = '0;
        ir1_en   = 1'b0;
        ir1_next = '0;
        pc_en    = 1'b0;
        pc_next  = '0;

        // While ir1 is still arriving only heads wholly inside ir0 may go;
        // illegal heads are always presented so the consumer can halt on them.
        case (state_q)
            FILL1:   issue_valid = !legal || (npc < HALF);
            RUN:     issue_valid = 1'b1;
            default: issue_valid = 1'b0;
        endcase

        hs            = issue_valid & issue_ready;
        issue_pc      = issue_valid ? pc : 4'd0;
        issue_illegal = issue_valid & ~legal;
        issue_len     = !issue_valid ? 3'd0 : (legal ? size : 3'd1);

        case (state_q)
            FILL0: begin
                mem_req  = 1'b1;
                mem_addr = fa_q;
                if (mem_ack) begin
                    ir0_en   = 1'b1;
                    ir0_next = mem_rdata;
                    fa_d     = fa_q + AW'(1);
                    state_d  = FILL1;
                end
            end
            FILL1: begin
                mem_req  = 1'b1;
                mem_addr = fa_q;
                if (mem_ack) begin
                    ir1_en   = 1'b1;
                    ir1_next = mem_rdata;
                    fa_d     = fa_q + AW'(1);
                    state_d  = RUN;
                end
                if (hs) begin
                    if (!legal) begin
                        state_d = HALT;
                    end else begin
                        pc_en   = 1'b1;
                        pc_next = npc[3:0];
                    end
                end
            end
            RUN: begin
                if (hs) begin
                    if (!legal) begin
                        state_d = HALT;
                    end else if (npc < HALF) begin
                        pc_en   = 1'b1;
                        pc_next = npc[3:0];
                    end else begin
                        // npc is 8..11 here, so dropping bit 3 rebases into the new ir0
                        ir0_en   = 1'b1;
                        ir0_next = ir1;
                        pc_en    = 1'b1;
                        pc_next  = {1'b0, npc[2:0]};
                        state_d  = FILL1;
                    end
                end
            end
            default: ;
        endcase

        if (redir) begin
            ir0_en   = 1'b0;
            ir0_next = '0;
            ir1_en   = 1'b0;
            ir1_next = '0;
            pc_en    = 1'b1;
            pc_next  = {1'b0, redirect_nib};
            fa_d     = redirect_waddr;
            state_d  = FILL0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            fa_q    <= '0;
        end else begin
            state_q <= state_d;
            fa_q    <= fa_d;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: plays core and instruction memory, checks issues
// against a flat nibble-stream model of memory.
module tb_fetch_sequencer;

    localparam int AW = 30;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_waddr = '0;
    logic [2:0]    redirect_nib = '0;
    logic          mem_req, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rdata;
    logic [31:0]   ir0 = '0, ir1 = '0;
    logic [3:0]    pc = '0;
    logic [31:0]   ir0_next, ir1_next;
    logic          ir0_en, ir1_en, pc_en;
    logic [3:0]    pc_next;
    logic          issue_valid, issue_illegal;
    logic          issue_ready = 1'b0;
    logic [3:0]    issue_pc;
    logic [2:0]    issue_len;

    logic [31:0] mem [256];
    logic [3:0]  legal_nib [9] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h9, 4'hC, 4'hD};
    int          ack_delay = 0;
    bit          rand_ack = 1'b0;
    bit          rnd_q = 1'b0;
    int          wait_cnt = 0;
    int          n_chk = 0, n_pass = 0;

    fetch_sequencer #(.AW(AW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .redirect       (redirect),
        .redirect_waddr (redirect_waddr),
        .redirect_nib   (redirect_nib),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .ir0            (ir0),
        .ir1            (ir1),
        .pc             (pc),
        .ir0_next       (ir0_next),
        .ir1_next       (ir1_next),
        .ir0_en         (ir0_en),
        .ir1_en         (ir1_en),
        .pc_next        (pc_next),
        .pc_en          (pc_en),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .issue_pc       (issue_pc),
        .issue_len      (issue_len),
        .issue_illegal  (issue_illegal)
    );

    always #5 clk = ~clk;

    // core registers
    always @(posedge clk) begin
        if (ir0_en) ir0 <= ir0_next;
        if (ir1_en) ir1 <= ir1_next;
        if (pc_en)  pc  <= pc_next;
    end

    // memory: fixed wait states or random grants
    assign mem_ack   = mem_req && (rand_ack ? rnd_q : (wait_cnt >= ack_delay));
    assign mem_rdata = mem[mem_addr[7:0]];
    always @(posedge clk) begin
        rnd_q    <= 1'($urandom_range(0, 1));
        wait_cnt <= (!mem_req || mem_ack || redirect) ? 0 : wait_cnt + 1;
    end

    function automatic int ref_len(input logic [3:0] h);
        case (h)
            4'h0, 4'h4, 4'h8, 4'h9, 4'hC, 4'hD: return 1;
            4'h1:    return 2;
            4'h2:    return 3;
            4'h3:    return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic [3:0] mem_nib(input int a);
        logic [31:0] w;
        w = mem[(a >> 3) & 255];
        return w[(a & 7) * 4 +: 4];
    endfunction

    task automatic do_redirect(input logic [AW-1:0] wa, input logic [2:0] nb);
        @(negedge clk);
        redirect = 1'b1; redirect_waddr = wa; redirect_nib = nb;
        @(negedge clk);
        redirect = 1'b0;
    endtask

    task automatic test_reset();
        bit seen;
        reset_n = 1'b0;
        #1;
        n_chk++; if (mem_req !== 1'b0 || mem_addr !== '0) $display("FAIL reset_mem: req=%b addr=%h exp 0/0", mem_req, mem_addr); else n_pass++;
        n_chk++; if ({ir0_en, ir1_en, pc_en} !== 3'b0) $display("FAIL reset_en: en=%b exp 000", {ir0_en, ir1_en, pc_en}); else n_pass++;
        n_chk++; if ({ir0_next, ir1_next, pc_next} !== '0) $display("FAIL reset_next: %h %h %h exp 0", ir0_next, ir1_next, pc_next); else n_pass++;
        n_chk++; if ({issue_valid, issue_illegal, issue_pc, issue_len} !== '0) $display("FAIL reset_issue: v=%b il=%b pc=%h len=%0d exp 0", issue_valid, issue_illegal, issue_pc, issue_len); else n_pass++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (5) begin @(negedge clk); #1; if (mem_req) seen = 1'b1; end
        n_chk++; if (seen !== 1'b0) $display("FAIL idle_no_fetch: mem_req seen=%b exp 0", seen); else n_pass++;
    endtask

    task automatic test_basic();
        int k, cyc, first;
        mem[16] = 32'h11111111; mem[17] = 32'h22222222; mem[18] = 32'h33333333;
        ack_delay = 0; issue_ready = 1'b1;
        do_redirect(16, 0);
        #1;
        n_chk++; if (mem_req !== 1'b1 || mem_addr !== 30'h10) $display("FAIL basic_fill0: req=%b addr=%h exp 1/10", mem_req, mem_addr); else n_pass++;
        k = 0; cyc = 0; first = -1;
        while (k < 4 && cyc < 20) begin
            @(negedge clk); #1; cyc++;
            if (issue_valid && issue_ready) begin
                if (first < 0) first = cyc;
                n_chk++; if (issue_pc !== 4'(2 * k) || issue_len !== 3'd2) $display("FAIL basic_issue%0d: pc=%0d len=%0d exp %0d/2", k, issue_pc, issue_len, 2 * k); else n_pass++;
                k++;
            end
        end
        n_chk++; if (k != 4 || first != 1) $display("FAIL basic_count: issues=%0d first_cycle=%0d exp 4/1", k, first); else n_pass++;
        @(negedge clk); #1;
        n_chk++; if (pc !== 4'd0 || ir0 !== 32'h22222222) $display("FAIL basic_shift: pc=%0d ir0=%h exp 0/22222222", pc, ir0); else n_pass++;
        n_chk++; if (mem_req !== 1'b1 || mem_addr !== 30'h12) $display("FAIL basic_refetch: req=%b addr=%h exp 1/12", mem_req, mem_addr); else n_pass++;
        issue_ready = 1'b0;
    endtask

    task automatic test_illegal();
        int cyc;
        bit bad;
        mem[32] = 32'h00000500; mem[33] = 32'h0;
        issue_ready = 1'b0;
        do_redirect(32, 2);
        cyc = 0; #1;
        while (!issue_valid && cyc < 20) begin @(negedge clk); #1; cyc++; end
        n_chk++; if (issue_valid !== 1'b1 || issue_illegal !== 1'b1 || issue_len !== 3'd1 || issue_pc !== 4'd2)
            $display("FAIL illegal_present: v=%b il=%b len=%0d pc=%0d exp 1/1/1/2", issue_valid, issue_illegal, issue_len, issue_pc); else n_pass++;
        @(negedge clk); issue_ready = 1'b1; #1;
        n_chk++; if (pc_en !== 1'b0) $display("FAIL illegal_pc_en: pc_en=%b exp 0", pc_en); else n_pass++;
        @(negedge clk); issue_ready = 1'b0; #1;
        n_chk++; if (pc !== 4'd2) $display("FAIL illegal_pc_hold: pc=%0d exp 2", pc); else n_pass++;
        bad = 1'b0;
        repeat (20) begin @(negedge clk); #1; if (mem_req || issue_valid) bad = 1'b1; end
        n_chk++; if (bad !== 1'b0) $display("FAIL halt_quiet: activity=%b exp 0", bad); else n_pass++;
    endtask

    task automatic test_redirect_ack();
        logic [31:0] old_ir0;
        ack_delay = 1000;
        do_redirect(30'h30, 0);
        old_ir0 = ir0;
        redirect = 1'b1; redirect_waddr = 30'h40; redirect_nib = 3'd3; ack_delay = 0;
        #1;
        n_chk++; if (ir0_en !== 1'b0 || ir1_en !== 1'b0) $display("FAIL redir_ack_en: ir0_en=%b ir1_en=%b exp 0/0", ir0_en, ir1_en); else n_pass++;
        n_chk++; if (pc_en !== 1'b1 || pc_next !== 4'd3) $display("FAIL redir_pc: en=%b next=%0d exp 1/3", pc_en, pc_next); else n_pass++;
        @(negedge clk);
        redirect = 1'b0; ack_delay = 1000;
        #1;
        n_chk++; if (mem_req !== 1'b1 || mem_addr !== 30'h40) $display("FAIL redir_addr: req=%b addr=%h exp 1/40", mem_req, mem_addr); else n_pass++;
        n_chk++; if (pc !== 4'd3 || ir0 !== old_ir0) $display("FAIL redir_state: pc=%0d ir0=%h exp 3/%h", pc, ir0, old_ir0); else n_pass++;
    endtask

    task automatic test_straddle();
        int cyc;
        mem[16'h50] = 32'h03000000; mem[16'h51] = 32'h11111111; mem[16'h52] = 32'h0;
        ack_delay = 3; issue_ready = 1'b1;
        do_redirect(30'h50, 6);
        cyc = 1; #1;
        while (!issue_valid && cyc < 40) begin @(negedge clk); #1; cyc++; end
        n_chk++; if (cyc != 9 || mem_req !== 1'b0) $display("FAIL straddle_wait: first_issue_cycle=%0d mem_req=%b exp 9/0", cyc, mem_req); else n_pass++;
        n_chk++; if (issue_pc !== 4'd6 || issue_len !== 3'd4 || ir1 !== 32'h11111111) $display("FAIL straddle_issue: pc=%0d len=%0d ir1=%h exp 6/4/11111111", issue_pc, issue_len, ir1); else n_pass++;
        @(negedge clk); #1;
        n_chk++; if (pc !== 4'd2 || ir0 !== 32'h11111111 || mem_addr !== 30'h52) $display("FAIL straddle_shift: pc=%0d ir0=%h addr=%h exp 2/11111111/52", pc, ir0, mem_addr); else n_pass++;
        issue_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int cyc;
        bit moved;
        logic [3:0] v_pc;
        logic [2:0] v_len;
        for (int i = 16'h60; i < 16'h64; i++) mem[i] = 32'h0;
        ack_delay = 0; issue_ready = 1'b0;
        do_redirect(30'h60, 0);
        cyc = 0; #1;
        while (!(issue_valid && !mem_req) && cyc < 20) begin @(negedge clk); #1; cyc++; end
        v_pc = issue_pc; v_len = issue_len;
        n_chk++; if (issue_valid !== 1'b1 || v_pc !== 4'd0 || v_len !== 3'd1) $display("FAIL bp_head: v=%b pc=%0d len=%0d exp 1/0/1", issue_valid, v_pc, v_len); else n_pass++;
        moved = 1'b0;
        repeat (5) begin
            @(negedge clk); #1;
            if (!issue_valid || issue_pc !== v_pc || issue_len !== v_len || pc_en) moved = 1'b1;
        end
        n_chk++; if (moved !== 1'b0) $display("FAIL bp_stable: changed=%b exp 0", moved); else n_pass++;
        issue_ready = 1'b1; #1;
        n_chk++; if (pc_en !== 1'b1 || pc_next !== 4'd1) $display("FAIL bp_release: en=%b next=%0d exp 1/1", pc_en, pc_next); else n_pass++;
        @(negedge clk); issue_ready = 1'b0;
    endtask

    task automatic test_random();
        int wa, nb, abs_n, k, cyc, len;
        logic [AW-1:0] exp_fa;
        logic [31:0] word;
        rand_ack = 1'b1;
        for (int it = 0; it < 4; it++) begin
            wa = $urandom_range(128, 200);
            nb = $urandom_range(0, 7);
            for (int w = wa; w < wa + 24; w++) begin
                for (int j = 0; j < 8; j++) word[j * 4 +: 4] = legal_nib[$urandom_range(0, 8)];
                mem[w] = word;
            end
            do_redirect(AW'(wa), 3'(nb));
            abs_n = wa * 8 + nb; exp_fa = AW'(wa); k = 0; cyc = 0;
            issue_ready = 1'($urandom_range(0, 1)); #1;
            while (k < 40 && cyc < 2000) begin
                if (mem_req && mem_ack) begin
                    n_chk++; if (mem_addr !== exp_fa) $display("FAIL rnd_fetch: addr=%h exp %h", mem_addr, exp_fa); else n_pass++;
                    exp_fa = exp_fa + 1'b1;
                end
                if (issue_valid && issue_ready) begin
                    len = ref_len(mem_nib(abs_n));
                    n_chk++; if (issue_pc !== 4'(abs_n & 7) || issue_pc !== pc || issue_len !== 3'(len) || issue_illegal !== 1'b0)
                        $display("FAIL rnd_issue: pc=%0d len=%0d il=%b exp %0d/%0d/0", issue_pc, issue_len, issue_illegal, abs_n & 7, len); else n_pass++;
                    abs_n += len; k++;
                end
                @(negedge clk); issue_ready = 1'($urandom_range(0, 1)); #1; cyc++;
            end
            n_chk++; if (k != 40) $display("FAIL rnd_progress: issues=%0d exp 40", k); else n_pass++;
        end
        rand_ack = 1'b0; issue_ready = 1'b0;
    endtask

    task automatic test_reset_run();
        bit seen;
        ack_delay = 0; issue_ready = 1'b1;
        do_redirect(30'h60, 0);
        repeat (6) @(negedge clk);
        reset_n = 1'b0; #1;
        n_chk++; if (mem_req !== 1'b0 || mem_addr !== '0 || issue_valid !== 1'b0) $display("FAIL rst_run_out: req=%b addr=%h v=%b exp 0", mem_req, mem_addr, issue_valid); else n_pass++;
        n_chk++; if ({ir0_en, ir1_en, pc_en} !== 3'b0 || issue_len !== 3'd0) $display("FAIL rst_run_en: en=%b len=%0d exp 0", {ir0_en, ir1_en, pc_en}, issue_len); else n_pass++;
        @(negedge clk); reset_n = 1'b1; issue_ready = 1'b0;
        seen = 1'b0;
        repeat (10) begin @(negedge clk); #1; if (mem_req || ir0_en || ir1_en) seen = 1'b1; end
        n_chk++; if (seen !== 1'b0) $display("FAIL rst_run_idle: activity=%b exp 0", seen); else n_pass++;
        do_redirect(30'h60, 0); #1;
        n_chk++; if (mem_req !== 1'b1 || mem_addr !== 30'h60) $display("FAIL rst_run_restart: req=%b addr=%h exp 1/60", mem_req, mem_addr); else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        test_reset();
        test_basic();
        test_illegal();
        test_redirect_ack();
        test_straddle();
        test_backpressure();
        test_random();
        test_reset_run();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
